// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative unsigned 32-bit multiply (shift-add) and divide
// (restoring), one result bit per cycle, single outstanding request.
module muldiv_unit #(
  parameter int ITER = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid,
  input  logic        mode,
  input  logic [31:0] in_A,
  input  logic [31:0] in_B,
  output logic        ready,
  output logic [31:0] out
);

  localparam int CW = $clog2(ITER + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic          op_div;
  logic [63:0]   opa;     // MUL: shifting multiplicand; DIV: low 32 = dividend/quotient
  logic [31:0]   opb;     // MUL: shifting multiplier;  DIV: divisor
  logic [63:0]   acc;     // MUL product accumulator
  logic [32:0]   rem;     // DIV partial remainder
  logic [32:0]   rem_sh;
  logic [33:0]   diff;
  logic          fits;
  logic          last;

  // BUSY holds ITER iteration cycles plus one cycle that commits the result
  assign last   = (cnt == CW'(ITER));

  // restoring-division trial subtract; divisor 0 always "fits", giving all-ones
  assign rem_sh = {rem[31:0], opa[31]};
  assign diff   = {rem, opa[31]} - {2'b00, opb};
  assign fits   = ~diff[33];

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // next-state and ready decode
  always_comb begin
    state_nx = state;
    ready    = 1'b0;
    case (state)
      IDLE: if (valid) state_nx = BUSY;
      BUSY: if (last)  state_nx = DONE;
      DONE: begin
        ready    = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // operand latch, per-cycle iteration and result commit
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      op_div <= 1'b0;
      opa    <= '0;
      opb    <= '0;
      acc    <= '0;
      rem    <= '0;
      out    <= '0;
    end else begin
      case (state)
        IDLE: if (valid) begin
          op_div <= mode;
          opa    <= {32'd0, in_A};
          opb    <= in_B;
          acc    <= '0;
          rem    <= '0;
          cnt    <= '0;
        end
        BUSY: if (!last) begin
          cnt <= cnt + 1'b1;
          if (op_div) begin
            rem        <= fits ? diff[32:0] : rem_sh;
            opa[31:0]  <= {opa[30:0], fits};
          end else begin
            if (opb[0]) acc <= acc + opa;
            opa <= opa << 1;
            opb <= opb >> 1;
          end
        end else begin
          out <= op_div ? opa[31:0] : acc[31:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus random
// operations compared against plain-arithmetic reference results.
module tb_muldiv_unit;

  localparam int ITER = 32;
  localparam int LAT  = ITER + 1;

  logic        clk = 1'b0;
  logic        rst, valid, mode;
  logic [31:0] in_A, in_B;
  logic        ready;
  logic [31:0] out;

  int n_cmp = 0;
  int n_err = 0;

  muldiv_unit #(.ITER(ITER)) dut (
    .clk(clk), .rst(rst), .valid(valid), .mode(mode),
    .in_A(in_A), .in_B(in_B), .ready(ready), .out(out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_res(input logic m, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    if (m) return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
    p = 64'(a) * 64'(b);
    return p[31:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic scramble();
    mode = 1'($urandom);
    in_A = $urandom;
    in_B = $urandom;
  endtask

  // watch n cycles and check that no ready pulse appears
  task automatic no_ready(input string tag, input int n);
    int pulses = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (ready) pulses++;
    end
    chk(tag, 32'(pulses), 32'd0);
  endtask

  // issue one op; inj>0 pulses a stray valid before edge inj after accept;
  // dn_inj presents valid during the DONE cycle
  task automatic run_op(input string tag, input logic m, input logic [31:0] a,
                        input logic [31:0] b, input int inj, input bit dn_inj);
    int lat = 0;
    logic [31:0] exp = ref_res(m, a, b);
    @(negedge clk);
    valid = 1'b1; mode = m; in_A = a; in_B = b;
    @(posedge clk); #1;
    valid = 1'b0;
    scramble();
    chk({tag, ".rdy_after_accept"}, 32'(ready), 32'd0);
    while (!ready && lat < 100) begin
      @(negedge clk);
      valid = (inj > 0 && lat + 1 == inj);
      scramble();
      @(posedge clk); #1;
      valid = 1'b0;
      lat++;
    end
    chk({tag, ".latency"}, 32'(lat), 32'(LAT));
    chk({tag, ".out"}, out, exp);
    @(negedge clk);
    valid = dn_inj;
    scramble();
    @(posedge clk); #1;
    valid = 1'b0;
    chk({tag, ".rdy_one_cycle"}, 32'(ready), 32'd0);
    chk({tag, ".out_hold"}, out, exp);
  endtask

  initial begin
    logic        m;
    logic [31:0] a, b;
    rst = 1'b1; valid = 1'b0; mode = 1'b0; in_A = '0; in_B = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.ready", 32'(ready), 32'd0);
    chk("reset.out", out, 32'd0);
    @(negedge clk); rst = 1'b0;

    // directed values
    run_op("mul7x6",   1'b0, 32'd7,          32'd6, 0, 1'b0);
    run_op("mul_ovf",  1'b0, 32'hFFFF_FFFF,  32'd2, 0, 1'b0);
    run_op("div100_7", 1'b1, 32'd100,        32'd7, 0, 1'b0);
    run_op("divmax_5", 1'b1, 32'hFFFF_FFFF,  32'd5, 0, 1'b0);
    run_op("div_by0",  1'b1, 32'd123,        32'd0, 0, 1'b0);

    // stray valid during BUSY, then during DONE: both ignored
    run_op("busy_ign", 1'b0, 32'd3, 32'd4, 10, 1'b0);
    no_ready("busy_ign.no_extra", LAT + 4);
    run_op("done_ign", 1'b1, 32'd9, 32'd3, 0, 1'b1);
    no_ready("done_ign.no_extra", LAT + 4);

    // reset mid-operation aborts and clears out
    @(negedge clk);
    valid = 1'b1; mode = 1'b1; in_A = 32'd100; in_B = 32'd7;
    @(negedge clk); valid = 1'b0;
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort.out", out, 32'd0);
    chk("abort.ready", 32'(ready), 32'd0);
    @(negedge clk); rst = 1'b0;
    no_ready("abort.no_ready", LAT + 4);
    chk("abort.out_still0", out, 32'd0);
    run_op("after_abort", 1'b0, 32'd5, 32'd5, 0, 1'b0);

    // request presented together with reset is dropped
    @(negedge clk);
    rst = 1'b1; valid = 1'b1; mode = 1'b0; in_A = 32'd11; in_B = 32'd11;
    @(negedge clk);
    rst = 1'b0; valid = 1'b0;
    no_ready("rst_prio.no_ready", LAT + 4);

    // random operations
    for (int i = 0; i < 24; i++) begin
      m = 1'($urandom);
      a = $urandom;
      case ($urandom_range(3))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(15));
        2:       b = $urandom >> $urandom_range(31);
        default: b = $urandom;
      endcase
      run_op($sformatf("rand%0d", i), m, a, b, 0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
